// File: rtl/mac_tree_pkg.sv
// rtl/mac_tree_pkg.sv - shared types and helpers for the multi-lane multiply-add-tree engine
//
// Holds the default-width element typedefs, the adder-tree level width
// function and the signed saturation bounds used by mac_tree_array.

package mac_tree_pkg;

    localparam int ACCU_NUM_D = 8;
    localparam int BW_ACT_D   = 8;
    localparam int BW_WET_D   = 8;
    localparam int BW_ACCU_D  = 32;
    localparam int BW_OUT_D   = 8;
    localparam int BW_PROD_D  = BW_ACT_D + BW_WET_D;

    typedef logic signed [BW_ACT_D-1:0]  act_t;
    typedef logic signed [BW_WET_D-1:0]  wet_t;
    typedef logic signed [BW_PROD_D-1:0] prod_t;
    typedef logic signed [BW_ACCU_D-1:0] acc_t;
    typedef logic signed [BW_OUT_D-1:0]  out_t;

    // Width of adder-tree level k (level 0 = the products themselves).
    function automatic int tree_width(input int bw_in, input int k);
        return bw_in + k;
    endfunction

    // Largest value representable in a signed bw_out-bit result.
    function automatic longint sat_hi(input int bw_out);
        return (longint'(1) << (bw_out - 1)) - 1;
    endfunction

    // Smallest value representable in a signed bw_out-bit result.
    function automatic longint sat_lo(input int bw_out);
        return -(longint'(1) << (bw_out - 1));
    endfunction

endpackage

// File: rtl/mac_tree_array_adder_tree.sv
// rtl/mac_tree_array_adder_tree.sv - registered pairwise adder tree for one lane
//
// Ports:
//   clk, reset  - clock, synchronous active-high reset
//   en          - global stall enable; every level holds while low
//   in_data     - ACCU_NUM signed operands of BW_IN bits
//   out_sum     - registered sum, L = clog2(ACCU_NUM) cycles after in_data
//
// The tree is laid out as a heap: node j sums children 2j and 2j+1, with the
// operands occupying indices ACCU_NUM..2*ACCU_NUM-1 and the root at node 1.
// Nodes are stored at the final width; each level's value is its own-width
// sum sign-extended, which is exact because no level can overflow its width.

module adder_tree
    import mac_tree_pkg::*;
#(
    parameter int  ACCU_NUM = 8,
    parameter int  BW_IN    = 16,
    localparam int L        = $clog2(ACCU_NUM),
    localparam int BW_SUM   = tree_width(BW_IN, L)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           en,
    input  logic [ACCU_NUM-1:0][BW_IN-1:0] in_data,
    output logic signed [BW_SUM-1:0]       out_sum
);

    logic signed [BW_SUM-1:0] node [1:ACCU_NUM-1];
    logic signed [BW_SUM-1:0] kid  [2:2*ACCU_NUM-1];

    always_comb begin
        for (int c = 2; c < ACCU_NUM; c++) begin
            kid[c] = node[c];
        end
        for (int i = 0; i < ACCU_NUM; i++) begin
            kid[ACCU_NUM + i] = BW_SUM'($signed(in_data[i]));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int j = 1; j < ACCU_NUM; j++) begin
                node[j] <= '0;
            end
        end else if (en) begin
            for (int j = 1; j < ACCU_NUM; j++) begin
                node[j] <= kid[2*j] + kid[2*j + 1];
            end
        end
    end

    assign out_sum = node[1];

endmodule

// File: rtl/mac_tree_array.sv
// rtl/mac_tree_array.sv - pipelined multi-lane multiply-add-tree engine with round/saturate
//
// Ports:
//   clk, reset           - clock, synchronous active-high reset
//   in_valid/in_ready    - input beat handshake; in_last closes a group
//   act_in               - MAC_NUM x ACCU_NUM signed activations
//   wet_in               - ACCU_NUM signed weights shared by all lanes
//   shift_num            - rounding right-shift, taken from the last beat
//   relu_en              - only with MAC_TREE_RELU_EN; zero negative results
//   out_valid/out_ready  - result handshake
//   out_data, out_sat    - per-lane results and saturation flags
//
// Pipeline: P (products) -> T1..TL (adder tree) -> A (accumulate) ->
// S (round/shift/saturate) -> O (output register). A single global enable
// freezes every stage while a result waits on out_ready.

module mac_tree_array
    import mac_tree_pkg::*;
#(
    parameter int MAC_NUM  = 4,
    parameter int ACCU_NUM = 8,
    parameter int BW_ACT   = 8,
    parameter int BW_WET   = 8,
    parameter int BW_ACCU  = 32,
    parameter int BW_OUT   = 8
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic                                      in_valid,
    output logic                                      in_ready,
    input  logic                                      in_last,
    input  logic [MAC_NUM-1:0][ACCU_NUM-1:0][BW_ACT-1:0] act_in,
    input  logic [ACCU_NUM-1:0][BW_WET-1:0]           wet_in,
    input  logic [7:0]                                shift_num,
`ifdef MAC_TREE_RELU_EN
    input  logic                                      relu_en,
`endif
    output logic                                      out_valid,
    input  logic                                      out_ready,
    output logic [MAC_NUM-1:0][BW_OUT-1:0]            out_data,
    output logic [MAC_NUM-1:0]                        out_sat
);

    localparam int L       = $clog2(ACCU_NUM);
    localparam int BW_PROD = BW_ACT + BW_WET;
    localparam int BW_SUM  = tree_width(BW_PROD, L);
    localparam int BW_RND  = BW_ACCU + 1;

    localparam logic signed [BW_RND-1:0] SAT_HI = BW_RND'(sat_hi(BW_OUT));
    localparam logic signed [BW_RND-1:0] SAT_LO = BW_RND'(sat_lo(BW_OUT));

    logic en;
    logic relu_in;

    assign en       = !out_valid || out_ready;
    assign in_ready = en;

`ifdef MAC_TREE_RELU_EN
    assign relu_in = relu_en;
`else
    assign relu_in = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Sidebands travel with the data through P and the L tree levels.
    // ------------------------------------------------------------------
    logic       sb_vld   [0:L];
    logic       sb_last  [0:L];
    logic [7:0] sb_shift [0:L];
    logic       sb_relu  [0:L];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k <= L; k++) begin
                sb_vld[k]   <= 1'b0;
                sb_last[k]  <= 1'b0;
                sb_shift[k] <= '0;
                sb_relu[k]  <= 1'b0;
            end
        end else if (en) begin
            sb_vld[0]   <= in_valid;
            sb_last[0]  <= in_last;
            sb_shift[0] <= shift_num;
            sb_relu[0]  <= relu_in;
            for (int k = 1; k <= L; k++) begin
                sb_vld[k]   <= sb_vld[k-1];
                sb_last[k]  <= sb_last[k-1];
                sb_shift[k] <= sb_shift[k-1];
                sb_relu[k]  <= sb_relu[k-1];
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage P: full-width signed products.
    // ------------------------------------------------------------------
    logic [MAC_NUM-1:0][ACCU_NUM-1:0][BW_PROD-1:0] prod_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            prod_q <= '0;
        end else if (en) begin
            for (int m = 0; m < MAC_NUM; m++) begin
                for (int i = 0; i < ACCU_NUM; i++) begin
                    prod_q[m][i] <= BW_PROD'($signed(act_in[m][i])) *
                                    BW_PROD'($signed(wet_in[i]));
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stages T1..TL: one adder tree per lane.
    // ------------------------------------------------------------------
    logic signed [BW_SUM-1:0] tree_sum [MAC_NUM];

    for (genvar m = 0; m < MAC_NUM; m++) begin : g_lane
        adder_tree #(
            .ACCU_NUM (ACCU_NUM),
            .BW_IN    (BW_PROD)
        ) u_tree (
            .clk     (clk),
            .reset   (reset),
            .en      (en),
            .in_data (prod_q[m]),
            .out_sum (tree_sum[m])
        );
    end

    // ------------------------------------------------------------------
    // Stage A: group accumulation. 'first' re-arms after every last beat,
    // so a new group overwrites rather than adds; bubbles leave acc alone.
    // a_vld marks the beat that closes a group.
    // ------------------------------------------------------------------
    logic signed [BW_ACCU-1:0] acc [MAC_NUM];
    logic                      first;
    logic                      a_vld;
    logic [7:0]                a_shift;
    logic                      a_relu;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int m = 0; m < MAC_NUM; m++) begin
                acc[m] <= '0;
            end
            first   <= 1'b1;
            a_vld   <= 1'b0;
            a_shift <= '0;
            a_relu  <= 1'b0;
        end else if (en) begin
            a_vld   <= sb_vld[L] && sb_last[L];
            a_shift <= sb_shift[L];
            a_relu  <= sb_relu[L];
            if (sb_vld[L]) begin
                for (int m = 0; m < MAC_NUM; m++) begin
                    if (first) begin
                        acc[m] <= BW_ACCU'(tree_sum[m]);
                    end else begin
                        acc[m] <= acc[m] + BW_ACCU'(tree_sum[m]);
                    end
                end
                first <= sb_last[L];
            end
        end
    end

    // ------------------------------------------------------------------
    // Round-half-up shift in BW_ACCU+1 bits, then clamp. Shifts at or past
    // the accumulator width collapse to the sign (0 or -1) directly, since
    // the rounding constant would otherwise flip small negatives to 0.
    // ------------------------------------------------------------------
    logic [MAC_NUM-1:0][BW_OUT-1:0] res_c;
    logic [MAC_NUM-1:0]             sat_c;
    logic signed [BW_RND-1:0]       wide_c;
    logic signed [BW_RND-1:0]       r_c;

    always_comb begin
        res_c  = '0;
        sat_c  = '0;
        wide_c = '0;
        r_c    = '0;
        for (int m = 0; m < MAC_NUM; m++) begin
            wide_c = BW_RND'(acc[m]);
            if (a_shift == 8'd0) begin
                r_c = wide_c;
            end else if (int'(a_shift) >= BW_ACCU) begin
                r_c = acc[m][BW_ACCU-1] ? '1 : '0;
            end else begin
                r_c = (wide_c + (BW_RND'(1) << (a_shift - 8'd1))) >>> a_shift;
            end

            if (r_c > SAT_HI) begin
                res_c[m] = SAT_HI[BW_OUT-1:0];
                sat_c[m] = 1'b1;
            end else if (r_c < SAT_LO) begin
                res_c[m] = SAT_LO[BW_OUT-1:0];
                sat_c[m] = 1'b1;
            end else begin
                res_c[m] = r_c[BW_OUT-1:0];
            end

            // ReLU acts after saturation and leaves the saturation flag as is.
            if (a_relu && res_c[m][BW_OUT-1]) begin
                res_c[m] = '0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage S: registered round/saturate result.
    // ------------------------------------------------------------------
    logic                           s_vld;
    logic [MAC_NUM-1:0][BW_OUT-1:0] s_data;
    logic [MAC_NUM-1:0]             s_sat;

    always_ff @(posedge clk) begin
        if (reset) begin
            s_vld  <= 1'b0;
            s_data <= '0;
            s_sat  <= '0;
        end else if (en) begin
            s_vld  <= a_vld;
            s_data <= res_c;
            s_sat  <= sat_c;
        end
    end

    // ------------------------------------------------------------------
    // Stage O: output register. en already folds in the hold condition,
    // so a handshake clears valid unless a new result arrives the same cycle.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sat   <= '0;
        end else if (en) begin
            out_valid <= s_vld;
            if (s_vld) begin
                out_data <= s_data;
                out_sat  <= s_sat;
            end
        end
    end

endmodule
